// File: rtl/core_bus_arb_pkg.sv
// core_bus_arb_pkg: shared encodings, command type and helpers for the memory-bus arbiter
package core_bus_arb_pkg;
  localparam int ADDR_W = 32;
  localparam logic HOLD_ENABLE = 1'b1;
  localparam logic HOLD_DISABLE = 1'b0;
  localparam logic [1:0] GRANT_NONE = 2'd0;
  localparam logic [1:0] GRANT_M0 = 2'd1;
  localparam logic [1:0] GRANT_M1 = 2'd2;
  localparam logic [1:0] GRANT_M2 = 2'd3;
  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_BUSY = 1'b1;
  typedef struct packed {
    logic we;
    logic [ADDR_W-1:0] addr;
    logic [31:0] wdata;
  } bus_cmd_t;
  function automatic logic [31:0] gate32(input logic en, input logic [31:0] v);
    return en ? v : '0;
  endfunction
endpackage

// File: rtl/core_bus_arb_if.sv
// core_bus_arb_if: one master-side req/ack memory channel
interface core_bus_arb_if;
  import core_bus_arb_pkg::*;
  logic req;
  logic we;
  logic [ADDR_W-1:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic ack;
  logic err;
  modport master (output req, we, addr, wdata, input rdata, ack, err);
  modport slave (input req, we, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/core_bus_arb_pick.sv
// core_bus_arb_pick: combinational priority picker, m0 > m2 > m1 unless m1 is promoted
module core_bus_arb_pick
  import core_bus_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic       promote,
  output logic [1:0] grant
);
  always_comb grant = (promote && req[1]) ? GRANT_M1 :
                      req[0] ? GRANT_M0 :
                      req[2] ? GRANT_M2 :
                      req[1] ? GRANT_M1 : GRANT_NONE;
endmodule

// File: rtl/core_bus_arb.sv
// core_bus_arb: three-master req/ack arbiter onto the single slave bus with timeout and fetch anti-starvation
module core_bus_arb
  import core_bus_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  core_bus_arb_if.slave     m0,
  core_bus_arb_if.slave     m1,
  core_bus_arb_if.slave     m2,
  output logic              s_req,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [31:0]       s_wdata,
  input  logic [31:0]       s_rdata,
  input  logic              s_ack,
  output logic              hold_flag_out
);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam int TMO_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  logic [0:0] state;
  logic [1:0] grant, win;
  bus_cmd_t cmd, win_cmd;
  logic [TMO_W-1:0] tmo_cnt;
  logic [STV_W-1:0] starve_cnt;
  logic busy, tmo_hit, done, promote;
  logic ack0, ack1, ack2;
  core_bus_arb_pick u_pick (
    .req({m2.req, m1.req, m0.req}),
    .promote(promote),
    .grant(win)
  );
  always_comb begin
    busy = state == ARB_BUSY;
    promote = starve_cnt == STV_MAX;
    tmo_hit = busy && (TIMEOUT != 0) && tmo_cnt == TMO_LAST && !s_ack;
    done = busy && (s_ack || tmo_hit);
    win_cmd = win == GRANT_M1 ? {m1.we, m1.addr, m1.wdata} :
              win == GRANT_M2 ? {m2.we, m2.addr, m2.wdata} :
                                {m0.we, m0.addr, m0.wdata};
    s_req = busy;
    s_we = busy && cmd.we;
    s_addr = busy ? cmd.addr : '0;
    s_wdata = busy ? cmd.wdata : '0;
    ack0 = done && grant == GRANT_M0;
    ack1 = done && grant == GRANT_M1;
    ack2 = done && grant == GRANT_M2;
  end
  // s_ack beats a coincident timeout, so rdata passes only on a real slave ack
  always_comb begin
    m0.ack = ack0;
    m1.ack = ack1;
    m2.ack = ack2;
    m0.err = ack0 && tmo_hit;
    m1.err = ack1 && tmo_hit;
    m2.err = ack2 && tmo_hit;
    m0.rdata = gate32(ack0 && s_ack, s_rdata);
    m1.rdata = gate32(ack1 && s_ack, s_rdata);
    m2.rdata = gate32(ack2 && s_ack, s_rdata);
    hold_flag_out = ((m0.req && !ack0) || (m1.req && !ack1)) ? HOLD_ENABLE : HOLD_DISABLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ARB_IDLE;
      grant <= GRANT_NONE;
      cmd <= '0;
      tmo_cnt <= '0;
    end else if (!busy) begin
      if (win != GRANT_NONE) begin
        state <= ARB_BUSY;
        grant <= win;
        cmd <= win_cmd;
        tmo_cnt <= '0;
      end
    end else if (done) begin
      state <= ARB_IDLE;
      grant <= GRANT_NONE;
    end else
      tmo_cnt <= tmo_cnt + TMO_W'(tmo_cnt != '1);
  always_ff @(posedge clk or posedge rst)
    if (rst)
      starve_cnt <= '0;
    else if (!busy && win == GRANT_M1)
      starve_cnt <= '0;
    else if (m1.req && grant != GRANT_M1 && !promote)
      starve_cnt <= starve_cnt + STV_W'(1);
endmodule

// File: tb/tb_core_bus_arb.sv
// tb_core_bus_arb: directed scenarios plus random traffic checked against a transaction-level arbiter model
module tb_core_bus_arb;
  import core_bus_arb_pkg::*;
  localparam int STARVE_LIMIT = 8;
  localparam int TIMEOUT = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_req, s_we, s_ack, hold_flag_out;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0] s_wdata, s_rdata;
  logic mreq[3], mwe[3], mack[3], merr[3];
  logic [ADDR_W-1:0] maddr[3];
  logic [31:0] mwdata[3], mrdata[3];
  int checks = 0;
  int failures = 0;
  bit act[3];
  int new_pct[3];
  int slave_mode, ack_pct, ack_at;
  bit rd_rand;
  int owner, age, starve;
  logic lwe;
  logic [ADDR_W-1:0] laddr;
  logic [31:0] lwdata;
  core_bus_arb_if m0 ();
  core_bus_arb_if m1 ();
  core_bus_arb_if m2 ();
  assign m0.req = mreq[0];
  assign m0.we = mwe[0];
  assign m0.addr = maddr[0];
  assign m0.wdata = mwdata[0];
  assign m1.req = mreq[1];
  assign m1.we = mwe[1];
  assign m1.addr = maddr[1];
  assign m1.wdata = mwdata[1];
  assign m2.req = mreq[2];
  assign m2.we = mwe[2];
  assign m2.addr = maddr[2];
  assign m2.wdata = mwdata[2];
  assign mack[0] = m0.ack;
  assign mack[1] = m1.ack;
  assign mack[2] = m2.ack;
  assign merr[0] = m0.err;
  assign merr[1] = m1.err;
  assign merr[2] = m2.err;
  assign mrdata[0] = m0.rdata;
  assign mrdata[1] = m1.rdata;
  assign mrdata[2] = m2.rdata;
  core_bus_arb #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .m0(m0),
    .m1(m1),
    .m2(m2),
    .s_req(s_req),
    .s_we(s_we),
    .s_addr(s_addr),
    .s_wdata(s_wdata),
    .s_rdata(s_rdata),
    .s_ack(s_ack),
    .hold_flag_out(hold_flag_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    owner = -1;
    age = 0;
    starve = 0;
    for (int i = 0; i < 3; i++) begin
      act[i] = 1'b0;
      mreq[i] = 1'b0;
    end
  endtask
  // compare DUT against the model for the current cycle, then advance the model across the coming edge
  task automatic model_check();
    logic [2:0] e_ack, e_err;
    logic [31:0] e_rd[3];
    int ord[3];
    int win;
    bit tmo;
    e_ack = '0;
    e_err = '0;
    for (int i = 0; i < 3; i++) e_rd[i] = '0;
    if (owner >= 0) begin
      tmo = !s_ack && TIMEOUT != 0 && age == TIMEOUT - 1;
      e_ack[owner] = s_ack || tmo;
      e_err[owner] = tmo;
      e_rd[owner] = s_ack ? s_rdata : 32'h0;
    end
    chk("s_req", 32'(s_req), 32'(owner >= 0));
    chk("s_we", 32'(s_we), 32'(owner >= 0 && lwe));
    chk("s_addr", s_addr, owner >= 0 ? laddr : 32'h0);
    chk("s_wdata", s_wdata, owner >= 0 ? lwdata : 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ack%0d", i), 32'(mack[i]), 32'(e_ack[i]));
      chk($sformatf("err%0d", i), 32'(merr[i]), 32'(e_err[i]));
      chk($sformatf("rdata%0d", i), mrdata[i], e_rd[i]);
    end
    chk("hold", 32'(hold_flag_out), 32'((mreq[0] && !e_ack[0]) || (mreq[1] && !e_ack[1])));
    if (starve == STARVE_LIMIT) ord = '{1, 0, 2};
    else ord = '{0, 2, 1};
    win = -1;
    if (owner < 0)
      for (int k = 0; k < 3; k++) if (win < 0 && mreq[ord[k]]) win = ord[k];
    if (win == 1) starve = 0;
    else if (mreq[1] && owner != 1 && starve < STARVE_LIMIT) starve++;
    if (owner < 0) begin
      if (win >= 0) begin
        owner = win;
        lwe = mwe[win];
        laddr = maddr[win];
        lwdata = mwdata[win];
        age = 0;
      end
    end else if (e_ack[owner]) owner = -1;
    else age++;
    for (int i = 0; i < 3; i++) if (e_ack[i]) act[i] = 1'b0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (!act[i] && $urandom_range(99) < new_pct[i]) begin
        act[i] = 1'b1;
        mwe[i] = 1'($urandom);
        maddr[i] = $urandom;
        mwdata[i] = $urandom;
      end
      mreq[i] = act[i];
    end
    s_rdata = rd_rand ? $urandom : 32'hDEAD_BEEF;
    s_ack = slave_mode == 0 ? ($urandom_range(99) < ack_pct) :
            slave_mode == 1 ? (owner >= 0 && age == ack_at - 1) : 1'b0;
    @(negedge clk);
    model_check();
  endtask
  task automatic drain();
    for (int c = 0; c < 40 && (act[0] || act[1] || act[2]); c++) step();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n_sreq, n_ack, n_hold, idx, gap;
    logic [31:0] got;
    logic [31:0] order[$];
    logic [31:0] exp_ord[3];
    for (int i = 0; i < 3; i++) begin
      mwe[i] = 1'b0;
      maddr[i] = '0;
      mwdata[i] = '0;
      new_pct[i] = 0;
    end
    s_ack = 1'b0;
    s_rdata = '0;
    slave_mode = 2;
    ack_pct = 0;
    ack_at = 1;
    rd_rand = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_s_req", 32'(s_req), 0);
    chk("rst_s_we", 32'(s_we), 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_s_wdata", s_wdata, 0);
    chk("rst_hold", 32'(hold_flag_out), 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_ack%0d", i), 32'(mack[i]), 0);
      chk($sformatf("rst_err%0d", i), 32'(merr[i]), 0);
      chk($sformatf("rst_rdata%0d", i), mrdata[i], 0);
    end
    rst = 1'b0;
    rd_rand = 1'b0;
    slave_mode = 1;
    ack_at = 3;
    act[0] = 1'b1;
    mwe[0] = 1'b0;
    maddr[0] = 32'h100;
    n_sreq = 0;
    n_ack = 0;
    n_hold = 0;
    got = '0;
    for (int c = 0; c < 6; c++) begin
      step();
      n_sreq += int'(s_req);
      n_hold += int'(hold_flag_out);
      if (mack[0]) begin
        n_ack++;
        got = mrdata[0];
        chk("t1_err", 32'(merr[0]), 0);
      end
    end
    chk("t1_sreq_cycles", n_sreq, 3);
    chk("t1_ack_cycles", n_ack, 1);
    chk("t1_rdata", got, 32'hDEAD_BEEF);
    chk("t1_hold_cycles", n_hold, 3);
    rd_rand = 1'b1;
    ack_at = 1;
    exp_ord = '{32'hA0, 32'hA2, 32'hA1};
    for (int i = 0; i < 3; i++) begin
      act[i] = 1'b1;
      mwe[i] = 1'b0;
      maddr[i] = 32'hA0 + 32'(i);
    end
    gap = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (s_req && (mack[0] || mack[1] || mack[2])) order.push_back(s_addr);
      if (act[1] && !hold_flag_out) gap++;
    end
    chk("t2_grants", order.size(), 3);
    for (int k = 0; k < 3; k++) if (k < order.size()) chk($sformatf("t2_order%0d", k), order[k], exp_ord[k]);
    chk("t2_hold_gap", gap, 0);
    new_pct[0] = 100;
    act[0] = 1'b1;
    act[1] = 1'b1;
    maddr[1] = 32'h1111_0000;
    idx = -1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (idx < 0 && s_req && s_addr == 32'h1111_0000) idx = c;
    end
    chk("t3_m1_grant_cycle", idx, 9);
    new_pct[0] = 0;
    drain();
    act[0] = 1'b1;
    maddr[0] = 32'h0000_0C00;
    act[1] = 1'b1;
    maddr[1] = 32'h0000_0C01;
    idx = -1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (idx < 0 && s_req) idx = int'(s_addr);
    end
    chk("t3_after_first", idx, 32'h0000_0C00);
    drain();
    slave_mode = 2;
    act[2] = 1'b1;
    maddr[2] = 32'h200;
    idx = -1;
    n_ack = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (mack[2]) begin
        n_ack++;
        idx = c;
        chk("t4_err", 32'(merr[2]), 1);
        chk("t4_rdata", mrdata[2], 0);
      end
    end
    chk("t4_ack_cycle", idx, 4);
    chk("t4_ack_count", n_ack, 1);
    chk("t4_idle", 32'(s_req), 0);
    slave_mode = 0;
    ack_pct = 100;
    n_ack = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_ack += int'(mack[0] || mack[1] || mack[2] || s_req);
    end
    chk("t4_stray", n_ack, 0);
    slave_mode = 1;
    ack_at = 4;
    act[2] = 1'b1;
    idx = -1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (mack[2]) begin
        idx = c;
        chk("t5_err", 32'(merr[2]), 0);
        chk("t5_rdata", mrdata[2], s_rdata);
      end
    end
    chk("t5_ack_cycle", idx, 4);
    slave_mode = 2;
    act[0] = 1'b1;
    mwe[0] = 1'b1;
    maddr[0] = 32'h300;
    mwdata[0] = 32'h5A5A_5A5A;
    step();
    step();
    chk("t6_busy", 32'(s_req), 1);
    chk("t6_we", 32'(s_we), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_sreq_async", 32'(s_req), 0);
    chk("t6_no_ack", 32'(mack[0]), 0);
    chk("t6_we_clr", 32'(s_we), 0);
    model_reset();
    #1 rst = 1'b0;
    slave_mode = 1;
    ack_at = 1;
    act[1] = 1'b1;
    mwe[1] = 1'b0;
    maddr[1] = 32'h400;
    idx = -1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (idx < 0 && s_req) idx = c;
    end
    chk("t6_regrant_latency", idx, 1);
    new_pct = '{25, 25, 25};
    slave_mode = 0;
    ack_pct = 45;
    repeat (400) step();
    ack_pct = 8;
    repeat (300) step();
    new_pct = '{0, 0, 0};
    slave_mode = 1;
    ack_at = 2;
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/core_bus_arb.md
# core_bus_arb

Shared memory-bus arbiter for the xRV32I core. It multiplexes three masters onto the single slave bus: data access from core_ex (m0), debug/external (m2) and instruction fetch (m1). Each transaction uses a req/ack handshake with a bounded timeout. It raises a hold request that core_ctrl ORs into its pipeline pause, so a stalled fetch or load freezes the pipeline.

## Interface
- STARVE_LIMIT, 8, consecutive cycles m1 may wait before it is promoted to top priority; range 1..255.
- TIMEOUT, 64, BUSY cycles without s_ack before the transaction is aborted with error; 0 disables the timeout.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mN_req  in  1  request from master N, N = 0, 1, 2; held until mN_ack.
- mN_we  in  1  write enable.
- mN_addr  in  `MemAddressBus`  address.
- mN_wdata  in  32  write data.
- mN_rdata  out  32  read data; valid when mN_ack = 1.
- mN_ack  out  1  one-cycle completion pulse.
- mN_err  out  1  qualifies mN_ack; 1 means the transaction timed out.
- s_req  out  1  slave request.
- s_we  out  1  slave write enable.
- s_addr  out  `MemAddressBus`  slave address.
- s_wdata  out  32  slave write data.
- s_rdata  in  32  slave read data.
- s_ack  in  1  slave completion pulse.
- hold_flag_out  out  1  `HoldEnable` while m0 or m1 is waiting; feeds core_ctrl.

## Operation
- FSM states: IDLE and BUSY. Registers: grant (NONE, M0, M1, M2), latched we/addr/wdata, timeout counter, starve counter.
- **IDLE arbitration**
  - If any mN_req is high, pick a winner and go to BUSY.
  - Latch the winner's we/addr/wdata and register grant.
  - Default priority is m0 > m2 > m1.
  - If starve_cnt == STARVE_LIMIT, the priority becomes m1 > m0 > m2.
- **BUSY**
  - s_req = 1; s_we/s_addr/s_wdata come from the latched registers.
  - The granted master's requests are not re-sampled while BUSY.
- **Completion**
  - When s_ack = 1 in BUSY: mG_ack = 1 and mG_rdata = s_rdata, both combinational pass-through; mG_err = 0.
  - Next state is IDLE.
- **Timeout**
  - tmo_cnt counts BUSY cycles and clears on entering BUSY.
  - If TIMEOUT != 0, tmo_cnt == TIMEOUT-1 and s_ack = 0: mG_ack = 1, mG_err = 1, mG_rdata = 0; next state is IDLE.
  - A late s_ack arriving in IDLE is ignored.
- **Starve counter**
  - Increments, saturating at STARVE_LIMIT, on every cycle where m1_req = 1 and grant != M1.
  - Clears when m1 is granted.
- **hold_flag_out** = `HoldEnable` iff (m0_req & ~m0_ack) | (m1_req & ~m1_ack); otherwise `HoldDisable`. Combinational.
- Ungranted masters: mN_ack = 0, mN_err = 0, mN_rdata = 0.
- If a master drops req while BUSY, the bus transaction still completes and the ack is issued anyway; the master ignores it.

## Timing
- Reset (asynchronous, immediate):
  - State is IDLE, grant is NONE, all counters are 0.
  - s_req = 0, s_we = 0, s_addr = 0, s_wdata = 0.
  - All mN_ack/mN_err/mN_rdata = 0.
- Reset mid-BUSY abandons the transaction with no ack; s_req drops asynchronously.
- Latency:
  - Request seen in IDLE at cycle T gives s_req = 1 at T+1.
  - Earliest ack is at T+1 if the slave acks immediately.
  - Back in IDLE at T+2, so the minimum is 2 cycles per transaction.
- Masters must drop or change req in the cycle after ack. A req still high in IDLE is treated as a new transaction.
- s_ack and the timeout in the same cycle: s_ack wins and err = 0.
- Simultaneous requests in IDLE are resolved in a single cycle by the priority rule; losers stay pending with ack = 0.
- Starve counter widths are $clog2(STARVE_LIMIT+1) bits; tmo_cnt width is $clog2(TIMEOUT+1) bits, minimum 1. Neither counter wraps.

## Structure
- defines.v gains:
  - grant encodings `GrantNone/`GrantM0/`GrantM1/`GrantM2 (2 bits);
  - state encodings `ArbIdle/`ArbBusy.
- `MemAddressBus` and `HoldEnable`/`HoldDisable` are reused from defines.v.
- One sub-module, core_bus_arb_pick: combinational priority picker.
  - Inputs: three req bits and the promote flag.
  - Output: grant encoding.
- Integration: hold_flag_out connects to a new hold input on core_ctrl, ORed with hold_flag_ex_in.

## Test plan
- Reset then single read: m0 read at addr 0x100 with the slave acking on its 3rd BUSY cycle and s_rdata = 0xDEADBEEF. Expect s_req for 3 cycles, m0_ack for 1 cycle with rdata 0xDEADBEEF, err = 0, and hold_flag_out high until the ack.
- Simultaneous m0, m1 and m2 requests: grant order m0, then m2, then m1. Check s_addr matches each master in turn, and that hold stays high while m1 waits.
- Starvation: m0 requests continuously with 1-cycle slave acks and m1_req is held high. m1 must be granted after exactly STARVE_LIMIT = 8 wait cycles, after which the counter is 0.
- Timeout: TIMEOUT = 4 and the slave never acks. Expect m2_ack and m2_err for 1 cycle after 4 BUSY cycles, m2_rdata = 0, return to IDLE, and a later stray s_ack has no effect.
- s_ack on the final timeout cycle: expect a normal ack with err = 0.
- Reset mid-BUSY on a write: s_req drops immediately, no ack is issued, and the next request is granted normally with T+1 latency.
